decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode pipeline stage between fetch and execute. Accepts one fetched instruction per cycle over a valid/ready handshake and decodes RV32I OP, OP-IMM, LUI and AUIPC into the execute-stage ALU controls (`op_ctrl`, `op_switch`), operand selects, register indices and immediate. Results are registered, and a 2-entry skid buffer keeps `in_ready` a pure register output. Execute consumes the output bundle directly.

## Interface
Parameters: none.
- `clk` input 1: clock; all state updates on rising edge.
- `rstn` input 1: one clock; reset is synchronous and active-low.
- `flush` input 1: synchronous kill of all held instructions.
- `in_valid` input 1: fetch offers `in_pc`/`in_instr`.
- `in_ready` output 1: registered; stage can accept this cycle.
- `in_pc` input 32: PC of offered instruction.
- `in_instr` input 32: offered instruction word.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: execute consumes bundle when `out_valid && out_ready`.
- `out_pc` output 32: PC of bundle.
- `out_op_ctrl` output 3: ALU op; ADD=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRX=101, OR=110, AND=111.
- `out_op_switch` output 1: ADD: 1=add, 0=sub; SRX: 1=logical, 0=arithmetic; 0 for all other ops.
- `out_op1_sel` output 2: 00=rs1, 01=pc, 10=zero.
- `out_use_imm` output 1: op2 = `out_imm` instead of rs2.
- `out_rs1`, `out_rs2`, `out_rd` output 5 each: register indices (instr[19:15], [24:20], [11:7]).
- `out_imm` output 32: decoded immediate.
- `out_rd_we` output 1: writes rd.
- `out_illegal` output 1: instruction not decodable by this stage.

## Operation
- Decode (combinational on accepted word, stored in entry):
  - OP (0110011): op_ctrl=funct3, use_imm=0, op1_sel=00, rd_we=1. funct7=0100000 legal only with funct3 000/101, giving op_switch=0; funct7=0000000 gives op_switch=1 for 000/101. Other funct7 -> illegal.
  - OP-IMM (0010011): op_ctrl=funct3, use_imm=1, op1_sel=00, rd_we=1, imm=sign-extended instr[31:20], op_switch=1 for 000. Shifts (001/101): imm={27'b0,instr[24:20]}; instr[31:25] must be 0000000 (op_switch=1), or 0100000 only for 101 (op_switch=0); else illegal.
  - LUI (0110111): ADD, op_switch=1, op1_sel=10, use_imm=1, imm={instr[31:12],12'b0}, rd_we=1.
  - AUIPC (0010111): as LUI but op1_sel=01.
  - Any other opcode or instr[1:0]!=11: illegal=1, rd_we=0, op_ctrl=000, op_switch=0, imm=0; still passed downstream in order.
- Storage: main register (drives outputs) + skid register. States:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1. Accept and consume -> ONE (main replaced); accept only -> FULL (new to skid); consume only -> EMPTY.
  - FULL: out_valid=1, in_ready=0. Consume -> ONE (skid moves to main); no accept possible.
- Ordering strictly preserved; no drop or duplicate except by flush.
- `flush`: next state EMPTY, both entries invalid; any transfer on the flush cycle is discarded on both sides. Flush has priority over all handshakes.
- Reset (`rstn`=0 at edge): state EMPTY; in_ready=1, out_valid=0, all other outputs 0. Reset has priority over flush.

## Timing
- Latency: accepted on edge N -> out_valid and bundle at N+1 (EMPTY/ONE).
- Throughput 1/cycle while out_ready=1.
- `in_ready` and all `out_*` are register outputs; no combinational input-to-output path.
- Outputs stable while out_valid=1 and out_ready=0.
- After FULL and one consume, in_ready returns to 1 on the following cycle.

## Test plan
- Add/sub: in 0x002081B3 then 0x402080B3, out_ready=1 -> consecutive bundles op_ctrl=000, op_switch 1 then 0, rs1=1, rs2=2, rd 3 then 1, rd_we=1, one cycle latency each.
- Immediates: 0xFFF00093 -> imm=0xFFFFFFFF, use_imm=1; 0x40335293 -> op_ctrl=101, op_switch=0, imm=3, rs1=6, rd=5; 0x123453B7 -> op1_sel=10, imm=0x12345000.
- Back-pressure: out_ready=0, push A, B -> in_ready=0 after B; C held; release out_ready -> A, B, C emitted in order, none lost.
- Illegal: 0x0000006F (JAL) and 0x7E2080B3 -> out_illegal=1, rd_we=0, pass in order.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the three instructions emerge.
- Reset mid-stream (FULL) -> next cycle out_valid=0, in_ready=1, all outputs 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode stage with registered outputs and a 2-entry
// skid buffer so that in_ready never depends combinationally on out_ready.
module decode_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [2:0]  out_op_ctrl,
  output logic        out_op_switch,
  output logic [1:0]  out_op1_sel,
  output logic        out_use_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_rd_we,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op_ctrl;
    logic        op_switch;
    logic [1:0]  op1_sel;
    logic        use_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rd_we;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, dec;
  logic   in_ready_q, out_valid_q;
  logic   accept, consume;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.illegal = 1'b1;
    unique case (opcode)
      7'b0110011: begin
        dec.op_ctrl = funct3;
        dec.rd_we   = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.illegal   = 1'b0;
          dec.op_switch = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.illegal   = 1'b0;
          dec.op_switch = 1'b0;
        end
      end
      7'b0010011: begin
        dec.op_ctrl = funct3;
        dec.use_imm = 1'b1;
        dec.rd_we   = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.imm = {27'b0, in_instr[24:20]};
          if (funct7 == 7'b0000000) begin
            dec.illegal   = 1'b0;
            dec.op_switch = (funct3 == 3'b101);
          end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
            dec.illegal   = 1'b0;
            dec.op_switch = 1'b0;
          end
        end else begin
          dec.illegal   = 1'b0;
          dec.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
          dec.op_switch = (funct3 == 3'b000);
        end
      end
      7'b0110111, 7'b0010111: begin
        dec.illegal   = 1'b0;
        dec.op_switch = 1'b1;
        dec.op1_sel   = opcode[5] ? 2'b10 : 2'b01;
        dec.use_imm   = 1'b1;
        dec.imm       = {in_instr[31:12], 12'b0};
        dec.rd_we     = 1'b1;
      end
      default: ;
    endcase
    // Illegal words still travel downstream, but must not look like real ALU work.
    if (dec.illegal) begin
      dec.op_ctrl   = 3'b000;
      dec.op_switch = 1'b0;
      dec.op1_sel   = 2'b00;
      dec.use_imm   = 1'b0;
      dec.imm       = '0;
      dec.rd_we     = 1'b0;
    end
  end

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && consume) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = StFull;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = main_q.pc;
  assign out_op_ctrl   = main_q.op_ctrl;
  assign out_op_switch = main_q.op_switch;
  assign out_op1_sel   = main_q.op1_sel;
  assign out_use_imm   = main_q.use_imm;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_imm       = main_q.imm;
  assign out_rd_we     = main_q.rd_we;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, back-pressure, illegal words,
// flush and reset from the FULL state.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  out_op_ctrl;
  logic        out_op_switch;
  logic [1:0]  out_op1_sel;
  logic        out_use_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_rd_we;
  logic        out_illegal;

  int n_checks = 0;
  int n_fails  = 0;

  decode_stage dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_op_ctrl  (out_op_ctrl),
    .out_op_switch(out_op_switch),
    .out_op1_sel  (out_op1_sel),
    .out_use_imm  (out_use_imm),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_imm      (out_imm),
    .out_rd_we    (out_rd_we),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples both happen 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, ".pc"}, out_pc, 32'd0);
    check({tag, ".imm"}, out_imm, 32'd0);
    check({tag, ".ctrl"}, {out_op_ctrl, out_op_switch, out_op1_sel, out_use_imm,
                           out_rd_we, out_illegal}, 32'd0);
    check({tag, ".regs"}, {17'b0, out_rs1, out_rs2, out_rd}, 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check_zero_outputs("reset");
    rstn = 1'b1;

    // Add then sub, back to back
    drive(1'b1, 32'h002081B3, 32'h100);
    tick();
    check("add.valid", {31'b0, out_valid}, 32'd1);
    check("add.pc", out_pc, 32'h100);
    check("add.ctrl", {29'b0, out_op_ctrl}, 32'd0);
    check("add.sw", {31'b0, out_op_switch}, 32'd1);
    check("add.regs", {17'b0, out_rs1, out_rs2, out_rd}, {17'b0, 5'd1, 5'd2, 5'd3});
    check("add.we", {30'b0, out_rd_we, out_use_imm}, 32'b10);
    drive(1'b1, 32'h402080B3, 32'h104);
    tick();
    check("sub.pc", out_pc, 32'h104);
    check("sub.sw", {31'b0, out_op_switch}, 32'd0);
    check("sub.rd", {27'b0, out_rd}, 32'd1);
    check("sub.we", {31'b0, out_rd_we}, 32'd1);

    // Immediates
    drive(1'b1, 32'hFFF00093, 32'h108);
    tick();
    check("addi.imm", out_imm, 32'hFFFFFFFF);
    check("addi.use_imm", {31'b0, out_use_imm}, 32'd1);
    check("addi.sw", {31'b0, out_op_switch}, 32'd1);
    drive(1'b1, 32'h40335293, 32'h10C);
    tick();
    check("srai.ctrl", {29'b0, out_op_ctrl}, 32'd5);
    check("srai.sw", {31'b0, out_op_switch}, 32'd0);
    check("srai.imm", out_imm, 32'd3);
    check("srai.rs1", {27'b0, out_rs1}, 32'd6);
    check("srai.rd", {27'b0, out_rd}, 32'd5);
    drive(1'b1, 32'h123453B7, 32'h110);
    tick();
    check("lui.op1", {30'b0, out_op1_sel}, 32'd2);
    check("lui.imm", out_imm, 32'h12345000);
    check("lui.ctrl", {28'b0, out_op_ctrl, out_op_switch}, 32'd1);
    drive(1'b1, 32'h00001217, 32'h114);
    tick();
    check("auipc.op1", {30'b0, out_op1_sel}, 32'd1);
    check("auipc.imm", out_imm, 32'h00001000);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("drain.valid", {31'b0, out_valid}, 32'd0);

    // Back-pressure: A, B fill the stage, C waits
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h200);
    tick();
    check("bp.a.valid", {31'b0, out_valid}, 32'd1);
    check("bp.a.ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h402080B3, 32'h204);
    tick();
    check("bp.full.ready", {31'b0, in_ready}, 32'd0);
    check("bp.full.pc", out_pc, 32'h200);
    drive(1'b1, 32'hFFF00093, 32'h208);
    tick();
    check("bp.hold.ready", {31'b0, in_ready}, 32'd0);
    check("bp.hold.pc", out_pc, 32'h200);
    check("bp.hold.rd", {27'b0, out_rd}, 32'd3);
    out_ready = 1'b1;
    tick();
    check("bp.b.pc", out_pc, 32'h204);
    check("bp.b.ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp.c.pc", out_pc, 32'h208);
    check("bp.c.imm", out_imm, 32'hFFFFFFFF);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("bp.empty", {31'b0, out_valid}, 32'd0);

    // Illegal words pass through in order
    drive(1'b1, 32'h0000006F, 32'h300);
    tick();
    check("jal.pc", out_pc, 32'h300);
    check("jal.ill", {30'b0, out_illegal, out_rd_we}, 32'b10);
    drive(1'b1, 32'h7E2080B3, 32'h304);
    tick();
    check("badf7.pc", out_pc, 32'h304);
    check("badf7.ill", {30'b0, out_illegal, out_rd_we}, 32'b10);
    check("badf7.ctrl", {28'b0, out_op_ctrl, out_op_switch}, 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Flush while FULL with a new word offered
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h400);
    tick();
    drive(1'b1, 32'h402080B3, 32'h404);
    tick();
    check("fl.full", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 32'hFFF00093, 32'h408);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl.valid", {31'b0, out_valid}, 32'd0);
    check("fl.ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("fl.quiet1", {31'b0, out_valid}, 32'd0);
    tick();
    check("fl.quiet2", {31'b0, out_valid}, 32'd0);

    // Reset from FULL
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h500);
    tick();
    drive(1'b1, 32'h123453B7, 32'h504);
    tick();
    check("rst.full", {31'b0, in_ready}, 32'd0);
    rstn = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_zero_outputs("rst.mid");
    rstn      = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst.after", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
